// File: rtl/dmem_pkg.sv
// Shared types, limits and address-decode helper for the data-memory responder.
package dmem_pkg;

    localparam int unsigned DATA_W       = 32;
    localparam int unsigned BE_W         = DATA_W / 8;
    localparam int unsigned GNT_WAIT_MAX = 7;
    localparam int unsigned RD_LAT_MAX   = 4;

    // One response pipeline entry; payload fields are zero whenever valid is low.
    typedef struct packed {
        logic              valid;
        logic              err;
        logic [DATA_W-1:0] rdata;
    } dmem_rsp_t;

    // Grant FSM: GRANT once req has been held for the configured wait.
    typedef enum logic {
        GNT_IDLE  = 1'b0,
        GNT_GRANT = 1'b1
    } gnt_state_e;

    // Unsigned wrap-around subtract makes addresses below base fall out of range too.
    function automatic logic dmem_in_range(input logic [31:0] addr,
                                           input logic [31:0] base,
                                           input int unsigned depth);
        logic [31:0] off;
        off = addr - base;
        return off < (32'(depth) << 2);
    endfunction

endpackage

// File: rtl/dmem_rsp_pipe.sv
// Fixed-latency, in-order response shift register with synchronous flush.
module dmem_rsp_pipe
    import dmem_pkg::*;
#(
    parameter int unsigned RD_LAT = 1
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  dmem_rsp_t rsp_i,
    output dmem_rsp_t rsp_o
);

    // Out-of-range latencies are clamped to the supported 1..RD_LAT_MAX window.
    localparam int unsigned STAGES = (RD_LAT == 0)          ? 1 :
                                     (RD_LAT > RD_LAT_MAX)  ? RD_LAT_MAX : RD_LAT;

    dmem_rsp_t stage_q [STAGES];

    // Shift responses one stage per cycle; reset drops everything in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned s = 0; s < STAGES; s++) begin
                stage_q[s] <= '0;
            end
        end else begin
            stage_q[0] <= rsp_i;
            for (int unsigned s = 1; s < STAGES; s++) begin
                stage_q[s] <= stage_q[s-1];
            end
        end
    end

    assign rsp_o = stage_q[STAGES-1];

endmodule

// File: rtl/dmem_responder.sv
// Memory-side end of the core data port: wait-state grant, byte-writable
// word storage and a fixed-latency response pipeline.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
    parameter int unsigned GNT_WAIT    = 0,
    parameter int unsigned RD_LAT      = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              data_req_i,
    output logic              data_gnt_o,
    output logic              data_rvalid_o,
    input  logic [31:0]       data_addr_i,
    input  logic              data_we_i,
    input  logic [BE_W-1:0]   data_be_i,
    input  logic [DATA_W-1:0] data_wdata_i,
    output logic [DATA_W-1:0] data_rdata_o,
    output logic              data_err_o
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W = $clog2(GNT_WAIT_MAX + 1);
    localparam logic [CNT_W-1:0] GNT_WAIT_C = CNT_W'(GNT_WAIT);
    localparam gnt_state_e GNT_RESET_ST = (GNT_WAIT_C == '0) ? GNT_GRANT : GNT_IDLE;

    gnt_state_e        state_q, state_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic              accept;

    logic [31:0]       offset;
    logic              in_range;
    logic [IDX_W-1:0]  index;

    logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

    dmem_rsp_t         rsp_d;
    dmem_rsp_t         rsp_out;

    // Grant is gated by reset so nothing can be accepted on a reset edge.
    assign data_gnt_o = data_req_i && !rst_i && (state_q == GNT_GRANT);
    assign accept     = data_req_i && data_gnt_o;

    // Wait counter advances while req waits, clears on accept or when req drops.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        state_d    = state_q;
        if (!data_req_i || accept) begin
            wait_cnt_d = '0;
        end else begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
        state_d = (wait_cnt_d == GNT_WAIT_C) ? GNT_GRANT : GNT_IDLE;
    end

    // Grant FSM state and wait counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wait_cnt_q <= '0;
            state_q    <= GNT_RESET_ST;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            state_q    <= state_d;
        end
    end

    // Word index is the in-window byte offset with the lane bits dropped.
    assign offset   = data_addr_i - BASE_ADDR;
    assign in_range = dmem_in_range(data_addr_i, BASE_ADDR, DEPTH_WORDS);
    assign index    = IDX_W'(offset >> 2);

    // Byte-lane writes on accept; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (accept && data_we_i && in_range) begin
            for (int unsigned b = 0; b < BE_W; b++) begin
                if (data_be_i[b]) begin
                    mem_q[index][8*b +: 8] <= data_wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Response for this accept: full read word, or zero data for writes/errors.
    always_comb begin
        rsp_d = '0;
        if (accept) begin
            rsp_d.valid = 1'b1;
            if (!in_range) begin
                rsp_d.err = 1'b1;
            end else if (!data_we_i) begin
                rsp_d.rdata = mem_q[index];
            end
        end
    end

    dmem_rsp_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rsp_pipe (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .rsp_i  (rsp_d),
        .rsp_o  (rsp_out)
    );

    assign data_rvalid_o = rsp_out.valid;
    assign data_err_o    = rsp_out.err;
    assign data_rdata_o  = rsp_out.rdata;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: four instances with different wait/latency
// settings, a scoreboard model checked every cycle, plus directed literals.
module tb_dmem_responder;

    localparam int NI = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst   [NI];
    logic        req   [NI];
    logic        we    [NI];
    logic [31:0] addr  [NI];
    logic [3:0]  be    [NI];
    logic [31:0] wdata [NI];
    wire         gnt_o [NI];
    wire         rv_o  [NI];
    wire         err_o [NI];
    wire  [31:0] rd_o  [NI];

    function automatic int unsigned gw_of(input int g);
        return (g == 1) ? 3 : 0;
    endfunction

    function automatic int unsigned rl_of(input int g);
        case (g)
            0:       return 1;
            1:       return 2;
            2:       return 4;
            default: return 3;
        endcase
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        dmem_responder #(
            .DEPTH_WORDS (1024),
            .BASE_ADDR   (32'h0001_0000),
            .GNT_WAIT    (gw_of(g)),
            .RD_LAT      (rl_of(g))
        ) u_dut (
            .clk_i         (clk),
            .rst_i         (rst[g]),
            .data_req_i    (req[g]),
            .data_gnt_o    (gnt_o[g]),
            .data_rvalid_o (rv_o[g]),
            .data_addr_i   (addr[g]),
            .data_we_i     (we[g]),
            .data_be_i     (be[g]),
            .data_wdata_i  (wdata[g]),
            .data_rdata_o  (rd_o[g]),
            .data_err_o    (err_o[g])
        );
    end

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s inst %0d cycle %0d: got %h, expected %h", name, g, cyc, act, exp);
        end
    endtask

    // Model state: per-instance hold time, due-cycle response slots, word memory.
    bit          chk_en = 1'b0;
    int          held [NI];
    bit          sv   [NI][8];
    bit          se   [NI][8];
    bit          sk   [NI][8];
    logic [31:0] sd   [NI][8];
    logic [31:0] mmem [NI][1024];
    bit          mk   [NI][1024];

    // Observation logs used by the directed checks.
    int          gnt_n [NI];
    int          gnt_c [NI][64];
    int          rv_n  [NI];
    int          rv_c  [NI][64];
    logic [31:0] rv_d  [NI][64];
    logic        rv_e  [NI][64];

    // Compare process: expected gnt/rvalid/err/rdata every cycle for every instance.
    int          s, ns, idx;
    bit          eg;
    logic [31:0] off;
    always @(negedge clk) begin
        if (chk_en) begin
            for (int g = 0; g < NI; g++) begin
                s  = cyc % 8;
                eg = req[g] && !rst[g] && (held[g] >= int'(gw_of(g)));
                chk("gnt", g, 32'(gnt_o[g]), 32'(eg));
                chk("rvalid", g, 32'(rv_o[g]), 32'(sv[g][s]));
                if (sv[g][s]) begin
                    chk("err", g, 32'(err_o[g]), 32'(se[g][s]));
                    if (sk[g][s]) chk("rdata", g, rd_o[g], sd[g][s]);
                end else begin
                    chk("idle_rdata", g, rd_o[g], 32'h0);
                    chk("idle_err", g, 32'(err_o[g]), 32'h0);
                end
                if (rv_o[g] === 1'b1) begin
                    rv_c[g][rv_n[g] % 64] = cyc;
                    rv_d[g][rv_n[g] % 64] = rd_o[g];
                    rv_e[g][rv_n[g] % 64] = err_o[g];
                    rv_n[g]++;
                end
                if (gnt_o[g] === 1'b1) begin
                    gnt_c[g][gnt_n[g] % 64] = cyc;
                    gnt_n[g]++;
                end
                sv[g][s] = 1'b0;
                if (rst[g]) begin
                    for (int k = 0; k < 8; k++) sv[g][k] = 1'b0;
                    held[g] = 0;
                end else if (eg) begin
                    off = addr[g] - 32'h0001_0000;
                    ns  = int'((cyc + rl_of(g)) % 8);
                    sv[g][ns] = 1'b1;
                    se[g][ns] = 1'b0;
                    sd[g][ns] = 32'h0;
                    sk[g][ns] = 1'b1;
                    if (off >= 32'd4096) begin
                        se[g][ns] = 1'b1;
                    end else begin
                        idx = int'(off[11:2]);
                        if (we[g]) begin
                            for (int b = 0; b < 4; b++)
                                if (be[g][b]) mmem[g][idx][8*b +: 8] = wdata[g][8*b +: 8];
                            if (be[g] == 4'hF) mk[g][idx] = 1'b1;
                        end else begin
                            sd[g][ns] = mmem[g][idx];
                            sk[g][ns] = mk[g][idx];
                        end
                    end
                    held[g] = 0;
                end else if (req[g]) begin
                    held[g]++;
                end else begin
                    held[g] = 0;
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accept edge, req still high.
    task automatic xact(input int g, input logic w, input logic [31:0] a, input logic [3:0] bmask, input logic [31:0] d);
        bit got;
        got      = 1'b0;
        req[g]   = 1'b1;
        we[g]    = w;
        addr[g]  = a;
        be[g]    = bmask;
        wdata[g] = d;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (gnt_o[g] === 1'b1) got = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!got) begin
            n_checks++;
            n_err++;
            $display("FAIL gnt_timeout inst %0d addr %h: no grant seen, required one within 20 cycles", g, a);
            req[g] = 1'b0;
        end
    endtask

    task automatic idle(input int g);
        req[g] = 1'b0;
        we[g]  = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int t0, gb, rb;

    initial begin
        for (int g = 0; g < NI; g++) begin
            rst[g] = 1'b1; req[g] = 1'b0; we[g] = 1'b0;
            addr[g] = 32'h0; be[g] = 4'h0; wdata[g] = 32'h0;
        end
        @(posedge clk);
        #1 chk_en = 1'b1;
        @(negedge clk);
        chk("reset_gnt", 0, 32'(gnt_o[0]), 32'h0);
        chk("reset_rvalid", 0, 32'(rv_o[0]), 32'h0);
        chk("reset_rdata", 0, rd_o[0], 32'h0);
        chk("reset_err", 0, 32'(err_o[0]), 32'h0);
        @(posedge clk);
        #1;
        for (int g = 0; g < NI; g++) rst[g] = 1'b0;

        // Write then read back, zero wait, one-cycle latency.
        t0 = cyc; gb = gnt_n[0]; rb = rv_n[0];
        xact(0, 1'b1, 32'h0001_0010, 4'hF, 32'hDEADBEEF);
        xact(0, 1'b0, 32'h0001_0010, 4'h0, 32'h0);
        idle(0);
        wait_cyc(3);
        chk("t1_gnt_cycle", 0, gnt_c[0][gb % 64], t0);
        chk("t1_wr_rv_cycle", 0, rv_c[0][rb % 64], t0 + 1);
        chk("t1_wr_rdata", 0, rv_d[0][rb % 64], 32'h0);
        chk("t1_wr_err", 0, 32'(rv_e[0][rb % 64]), 32'h0);
        chk("t1_rd_rdata", 0, rv_d[0][(rb + 1) % 64], 32'hDEADBEEF);

        // Byte and half-word merges.
        rb = rv_n[0];
        xact(0, 1'b1, 32'h0001_0020, 4'hF, 32'h11223344);
        xact(0, 1'b1, 32'h0001_0020, 4'h1, 32'h000000AA);
        xact(0, 1'b1, 32'h0001_0020, 4'hC, 32'hBBCC0000);
        xact(0, 1'b0, 32'h0001_0020, 4'h0, 32'h0);
        idle(0);
        wait_cyc(3);
        chk("t2_merge_rdata", 0, rv_d[0][(rb + 3) % 64], 32'hBBCC33AA);

        // Out-of-range below base and just past the top; last word in range.
        rb = rv_n[0];
        xact(0, 1'b1, 32'h0001_0000, 4'hF, 32'h5A5A5A5A);
        xact(0, 1'b1, 32'h0000_FFFC, 4'hF, 32'hFFFFFFFF);
        xact(0, 1'b0, 32'h0001_1000, 4'hF, 32'h0);
        xact(0, 1'b0, 32'h0001_0000, 4'hF, 32'h0);
        xact(0, 1'b1, 32'h0001_0FFC, 4'hF, 32'h0BADF00D);
        xact(0, 1'b0, 32'h0001_0FFC, 4'h0, 32'h0);
        idle(0);
        wait_cyc(3);
        chk("t5_low_err", 0, 32'(rv_e[0][(rb + 1) % 64]), 32'h1);
        chk("t5_low_rdata", 0, rv_d[0][(rb + 1) % 64], 32'h0);
        chk("t5_high_err", 0, 32'(rv_e[0][(rb + 2) % 64]), 32'h1);
        chk("t5_high_rdata", 0, rv_d[0][(rb + 2) % 64], 32'h0);
        chk("t5_word0_kept", 0, rv_d[0][(rb + 3) % 64], 32'h5A5A5A5A);
        chk("t5_top_err", 0, 32'(rv_e[0][(rb + 5) % 64]), 32'h0);
        chk("t5_top_rdata", 0, rv_d[0][(rb + 5) % 64], 32'h0BADF00D);

        // Three wait states, two-cycle latency, exactly one response.
        t0 = cyc; gb = gnt_n[1]; rb = rv_n[1];
        xact(1, 1'b1, 32'h0001_0004, 4'hF, 32'hCAFEF00D);
        idle(1);
        wait_cyc(6);
        chk("t3_gnt_cycle", 1, gnt_c[1][gb % 64], t0 + 3);
        chk("t3_rv_cycle", 1, rv_c[1][rb % 64], t0 + 5);
        chk("t3_rv_count", 1, rv_n[1] - rb, 1);

        // Req dropped before grant: no grant, no response, counter restarts.
        gb = gnt_n[1]; rb = rv_n[1];
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h0001_0004; be[1] = 4'hF;
        wait_cyc(2);
        idle(1);
        wait_cyc(5);
        chk("t3_drop_gnt", 1, gnt_n[1] - gb, 0);
        chk("t3_drop_rv", 1, rv_n[1] - rb, 0);
        t0 = cyc;
        xact(1, 1'b0, 32'h0001_0004, 4'h0, 32'h0);
        idle(1);
        wait_cyc(6);
        chk("t3_retry_gnt_cycle", 1, gnt_c[1][gb % 64], t0 + 3);
        chk("t3_retry_rdata", 1, rv_d[1][rb % 64], 32'hCAFEF00D);

        // Back-to-back reads with four-cycle latency.
        xact(2, 1'b1, 32'h0001_0000, 4'hF, 32'd1);
        xact(2, 1'b1, 32'h0001_0004, 4'hF, 32'd2);
        xact(2, 1'b1, 32'h0001_0008, 4'hF, 32'd3);
        idle(2);
        wait_cyc(6);
        t0 = cyc; gb = gnt_n[2]; rb = rv_n[2];
        xact(2, 1'b0, 32'h0001_0000, 4'h0, 32'h0);
        xact(2, 1'b0, 32'h0001_0004, 4'h0, 32'h0);
        xact(2, 1'b0, 32'h0001_0008, 4'h0, 32'h0);
        idle(2);
        wait_cyc(8);
        for (int k = 0; k < 3; k++) begin
            chk("t4_gnt_cycle", 2, gnt_c[2][(gb + k) % 64], t0 + k);
            chk("t4_rv_cycle", 2, rv_c[2][(rb + k) % 64], t0 + 4 + k);
            chk("t4_rdata", 2, rv_d[2][(rb + k) % 64], 32'(k + 1));
        end

        // Reset with two reads in flight drops both; later request is served.
        xact(3, 1'b1, 32'h0001_0040, 4'hF, 32'h12345678);
        idle(3);
        wait_cyc(6);
        rb = rv_n[3];
        xact(3, 1'b0, 32'h0001_0040, 4'h0, 32'h0);
        xact(3, 1'b0, 32'h0001_0040, 4'h0, 32'h0);
        idle(3);
        rst[3] = 1'b1;
        wait_cyc(1);
        rst[3] = 1'b0;
        wait_cyc(6);
        chk("t6_flushed", 3, rv_n[3] - rb, 0);
        t0 = cyc;
        xact(3, 1'b0, 32'h0001_0040, 4'h0, 32'h0);
        idle(3);
        wait_cyc(5);
        chk("t6_after_count", 3, rv_n[3] - rb, 1);
        chk("t6_after_cycle", 3, rv_c[3][rb % 64], t0 + 3);
        chk("t6_after_rdata", 3, rv_d[3][rb % 64], 32'h12345678);

        wait_cyc(2);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before completion, required normal finish");
        $fatal(1, "watchdog expired");
    end

endmodule
